// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner arbiter for a shared 2:1 mux; forwards the owner's data with valid/ready.
// Latency: req to gnt is 1 cycle (registered); data path is combinational through the mux.
// Backpressure: o_ready low stalls the owner's beat and freezes the hold counter and ownership.
module mux2_rr_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] a_data,
   input  logic [WIDTH-1:0] b_data,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             o_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   // Counter value of the last beat allowed before a forced hand-over.
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic       sel_q, sel_d;
   logic [7:0] cnt_q, cnt_d;
   logic       last_b_q, last_b_d;   // 1 when B was the most recent owner
   logic       xfer;

   assign gnt_a   = (state_q == OWN_A);
   assign gnt_b   = (state_q == OWN_B);
   assign sel     = sel_q;
   assign o_valid = (state_q == OWN_A) ? req_a :
                    (state_q == OWN_B) ? req_b : 1'b0;
   assign o_data  = sel_q ? b_data : a_data;
   assign xfer    = o_valid & o_ready;

   // State, select, hold counter and fairness memory registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         cnt_q    <= 8'd0;
         last_b_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         last_b_q <= last_b_d;
      end
   end

   // Next-state: grant on request, release on drop, force a switch at the hold limit.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      last_b_d = last_b_q;
      case (state_q)
         IDLE: begin
            if (req_a && (!req_b || last_b_q)) begin
               state_d  = OWN_A;
               sel_d    = 1'b0;
               cnt_d    = 8'd0;
               last_b_d = 1'b0;
            end else if (req_b) begin
               state_d  = OWN_B;
               sel_d    = 1'b1;
               cnt_d    = 8'd0;
               last_b_d = 1'b1;
            end
         end
         OWN_A: begin
            if (!req_a) begin
               cnt_d = 8'd0;
               if (req_b) begin
                  state_d  = OWN_B;
                  sel_d    = 1'b1;
                  last_b_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer && cnt_q == HOLD_LAST) begin
               cnt_d = 8'd0;
               if (req_b) begin
                  state_d  = OWN_B;
                  sel_d    = 1'b1;
                  last_b_d = 1'b1;
               end
            end else if (xfer) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         OWN_B: begin
            if (!req_b) begin
               cnt_d = 8'd0;
               if (req_a) begin
                  state_d  = OWN_A;
                  sel_d    = 1'b0;
                  last_b_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer && cnt_q == HOLD_LAST) begin
               cnt_d = 8'd0;
               if (req_a) begin
                  state_d  = OWN_A;
                  sel_d    = 1'b0;
                  last_b_d = 1'b0;
               end
            end else if (xfer) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter: directed vector table plus randomized traffic against a model.
// Latency: outputs are sampled mid-cycle, after inputs settle.
// Backpressure: o_ready is driven both low and high in directed and random phases.
module tb_mux2_rr_arbiter;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_a, req_b, o_ready;
   logic [WIDTH-1:0] a_data, b_data;
   logic             gnt_a, gnt_b, sel, o_valid;
   logic [WIDTH-1:0] o_data;

   int n_vec  = 0;
   int n_miss = 0;

   mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a   (req_a),
      .req_b   (req_b),
      .a_data  (a_data),
      .b_data  (b_data),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b),
      .sel     (sel),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_ready (o_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst_n, ra, rb, rdy;
      logic ga, gb, sl, vld;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, ra, rb, rdy, ga, gb, sl, vld);
      vec_t v;
      v.rst_n = r; v.ra = ra; v.rb = rb; v.rdy = rdy;
      v.ga = ga; v.gb = gb; v.sl = sl; v.vld = vld;
      tbl.push_back(v);
   endfunction

   // Reference model: who owns the channel, beats taken in this grant, who won last.
   int   m_owner;      // 0 none, 1 A, 2 B
   int   m_beats;
   int   m_last;       // 1 A, 2 B
   logic m_sel;

   function automatic void m_reset();
      m_owner = 0; m_beats = 0; m_last = 2; m_sel = 1'b0;
   endfunction

   function automatic void m_grant(input int who);
      m_owner = who; m_beats = 0; m_last = who; m_sel = (who == 2);
   endfunction

   function automatic void m_step(input logic r, ra, rb, rdy);
      logic mine, other;
      if (!r) begin
         m_reset();
         return;
      end
      if (m_owner == 0) begin
         if (ra && rb)  m_grant(m_last == 1 ? 2 : 1);
         else if (ra)   m_grant(1);
         else if (rb)   m_grant(2);
      end else begin
         mine  = (m_owner == 1) ? ra : rb;
         other = (m_owner == 1) ? rb : ra;
         if (!mine) begin
            if (other) m_grant(3 - m_owner);
            else       m_owner = 0;
         end else if (rdy) begin
            m_beats++;
            if (m_beats == MAX_HOLD) begin
               m_beats = 0;
               if (other) m_grant(3 - m_owner);
            end
         end
      end
   endfunction

   task automatic check(input string name, input logic [WIDTH+3:0] got, input logic [WIDTH+3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s t=%0t: got {ga,gb,sel,vld,data}=%b expected %b", name, $time, got, exp);
      end
   endtask

   initial begin
      logic [WIDTH+3:0] exp;
      logic             ra, rb, rdy, r;
      logic [WIDTH-1:0] ad, bd;

      rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; o_ready = 1'b0;
      a_data = 8'h5A; b_data = 8'hC3;
      @(posedge clk);
      m_reset();

      // Reset held with both requesting, then contention A x4, B x4, A...
      add(0,1,1,1, 0,0,0,0);
      add(0,1,1,1, 0,0,0,0);
      add(1,1,1,1, 0,0,0,0);
      add(1,1,1,1, 1,0,0,1);
      add(1,1,1,1, 1,0,0,1);
      add(1,1,1,1, 1,0,0,1);
      add(1,1,1,1, 1,0,0,1);
      add(1,1,1,1, 0,1,1,1);
      add(1,1,1,1, 0,1,1,1);
      add(1,1,1,1, 0,1,1,1);
      add(1,1,1,1, 0,1,1,1);
      add(1,1,1,1, 1,0,0,1);
      add(1,1,1,1, 1,0,0,1);
      add(1,1,1,1, 1,0,0,1);
      // Stall at the hold limit: no switch until the beat is accepted.
      for (int i = 0; i < 5; i++) add(1,1,1,0, 1,0,0,1);
      add(1,1,1,1, 1,0,0,1);
      add(1,1,1,1, 0,1,1,1);
      // B releases early with A waiting, then both idle, then tie goes to B.
      add(1,1,0,1, 0,1,1,0);
      add(1,0,0,1, 1,0,0,0);
      add(1,0,0,1, 0,0,0,0);
      add(1,1,1,1, 0,0,0,0);
      add(1,1,1,1, 0,1,1,1);
      add(1,1,1,1, 0,1,1,1);
      // Mid-burst reset while B owns with two beats taken.
      add(0,1,1,1, 0,1,1,1);
      add(1,1,1,1, 0,0,0,0);
      add(1,1,1,1, 1,0,0,1);
      // Lone requester keeps the channel across counter wraps.
      for (int i = 0; i < 10; i++) add(1,1,0,1, 1,0,0,1);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n; req_a = tbl[i].ra; req_b = tbl[i].rb; o_ready = tbl[i].rdy;
         #1;
         exp = {tbl[i].ga, tbl[i].gb, tbl[i].sl, tbl[i].vld, (tbl[i].sl ? b_data : a_data)};
         check($sformatf("vec%0d", i), {gnt_a, gnt_b, sel, o_valid, o_data}, exp);
         m_step(tbl[i].rst_n, tbl[i].ra, tbl[i].rb, tbl[i].rdy);
      end

      // Randomized traffic with sticky requests, random stalls and rare resets.
      ra = 1'b0; rb = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         r   = ($urandom_range(0, 99) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         if (!(ra && gnt_a && !o_ready)) ra = ($urandom_range(0, 9) < (ra ? 8 : 4));
         else if ($urandom_range(0, 19) == 0) ra = 1'b0;
         if (!(rb && gnt_b && !o_ready)) rb = ($urandom_range(0, 9) < (rb ? 8 : 4));
         else if ($urandom_range(0, 19) == 0) rb = 1'b0;
         ad = 8'($urandom); bd = 8'($urandom);
         rst_n = r; req_a = ra; req_b = rb; o_ready = rdy; a_data = ad; b_data = bd;
         #1;
         exp = {(m_owner == 1), (m_owner == 2), m_sel,
                (m_owner == 1) ? ra : (m_owner == 2) ? rb : 1'b0,
                (m_sel ? bd : ad)};
         check($sformatf("rand%0d", c), {gnt_a, gnt_b, sel, o_valid, o_data}, exp);
         n_vec++;
         if (gnt_a && gnt_b) begin
            n_miss++;
            $display("FAIL onehot t=%0t: gnt_a=%b gnt_b=%b, required not both 1", $time, gnt_a, gnt_b);
         end
         m_step(r, ra, rb, rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
